// File: rtl/mem_wb_buf_pkg.sv
// Shared definitions for the MEM->WB staging buffer.
// Holds the result data width, register index width and the entry record
// exchanged between the memory stage, the buffer and the writeback stage.
package mem_wb_buf_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 5;

  // One buffered writeback request.
  typedef struct packed {
    logic              wb_e;
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
  } wb_entry_t;

  localparam int unsigned ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_fifo_mem.sv
// Entry storage for mem_wb_buf: DEPTH records, one synchronous write port and
// one asynchronous read port. Contents are not reset; validity is tracked by
// the pointers and count in the parent.
// Ports:
//   clk      - clock, write on rising edge
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - entry to write
//   i_raddr  - read address
//   o_rdata  - entry at i_raddr (combinational)
module wb_fifo_mem
  import mem_wb_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  wb_entry_t     i_wdata,
  input  logic [AW-1:0] i_raddr,
  output wb_entry_t     o_rdata
);

  wb_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_wb_buf.sv
// MEM->WB result buffer: circular FIFO of DEPTH writeback entries with a
// pulsed handshake on each side.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   wr_req/wr_wb_e/wr_data/wr_idx  - producer push request and entry fields
//   wr_ack                         - one-cycle pulse, push accepted
//   full, buf_avail                - count==DEPTH, count!=0
//   buf_re                         - consumer pop request
//   buf_rack                       - one-cycle pulse, popped entry on outputs
//   wb_e/dout/idxout               - last popped entry, held until next pop
module mem_wb_buf
  import mem_wb_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic              wr_wb_e,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  wr_idx,
  output logic              wr_ack,
  output logic              full,
  output logic              buf_avail,
  input  logic              buf_re,
  output logic              buf_rack,
  output logic              wb_e,
  output logic [DATA_W-1:0] dout,
  output logic [IDX_W-1:0]  idxout
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_wr_ack;
  logic          r_rack;
  wb_entry_t     r_out;

  logic          w_pop;
  logic          w_push;
  wb_entry_t     w_wdata;
  wb_entry_t     w_rdata;

  // A pending ack blocks the next accept, giving at most one transfer per two
  // cycles on each side. Pop never bypasses an empty buffer.
  assign w_pop  = buf_re & ~r_rack & (r_count != '0);
  // When full, a simultaneous pop frees the slot being written; the read port
  // still sees the old head because the write lands on the clock edge.
  assign w_push = wr_req & ~r_wr_ack & ((r_count != FullCount) | w_pop);

  assign w_wdata.wb_e = wr_wb_e;
  assign w_wdata.data = wr_data;
  assign w_wdata.idx  = wr_idx;

  wb_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_wr_ack <= 1'b0;
      r_rack   <= 1'b0;
      r_out    <= '0;
    end else begin
      r_wr_ack <= w_push;
      r_rack   <= w_pop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_out    <= w_rdata;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  assign wr_ack    = r_wr_ack;
  assign buf_rack  = r_rack;
  assign full      = (r_count == FullCount);
  assign buf_avail = (r_count != '0);
  assign wb_e      = r_out.wb_e;
  assign dout      = r_out.data;
  assign idxout    = r_out.idx;

endmodule
